lfsr_engine: RTL and testbench
==============================

// Module: lfsr_engine
// PURPOSE
//  Parametrised multi-step LFSR: Fibonacci or Galois mode selectable per cycle, 1..STEPS_MAX shifts per clock.
//  Seed load, zero-state lockup recovery, and automatic period measurement against the last seed.
//  Second-generation pseudo-random source for stimulus, scrambling and BIST pattern generation.
// PARAMETERS
//  WIDTH      16       state width in bits (>=3)
//  FIB_TAPS   16'hB400 Fibonacci tap mask; bit i set = state[i] feeds XOR (x^16+x^14+x^13+x^11+1)
//  GAL_POLY   16'h002D Galois feedback mask (x^16+x^5+x^3+x^2+1)
//  STEPS_MAX  8        max single steps per clock (>=1)
//  SW         $clog2(STEPS_MAX+1)  derived width of steps_i
// PORTS
//  clk            in   1          clock
//  nReset         in   1          reset, synchronous, active-high
//  seed_i         in   WIDTH      seed, sampled on reset and on load_i
//  load_i         in   1          load seed_i into state
//  en_i           in   1          advance state by steps_i this cycle
//  mode_i         in   1          0 = Fibonacci, 1 = Galois
//  steps_i        in   SW         single steps per cycle; 0 = hold, >STEPS_MAX clamps to STEPS_MAX
//  state_o        out  WIDTH      current LFSR state (registered)
//  bits_o         out  STEPS_MAX  per-step output bits from last advance, bit0 = first step; unused bits 0
//  wrap_o         out  1          1-cycle pulse: some intermediate state equalled the latched seed
//  lockup_o       out  1          1-cycle pulse: zero seed replaced by 1
//  period_o       out  WIDTH      step count at first wrap since last seed
//  period_valid_o out  1          period_o valid; cleared on reset/load
// BEHAVIOUR
//  - Priority per posedge: nReset > load_i > en_i. mode_i/steps_i sampled each cycle, no latching.
//  - Reset/load: state <= (seed_i==0) ? 1 : seed_i; seed_q <= same value; step_cnt <= 0.
//    Also bits_o <= 0, wrap_o <= 0, period_valid_o <= 0, period_o <= 0.
//    lockup_o <= (seed_i==0) on load only; lockup_o = 0 on reset.
//  - Fibonacci step: fb = ^(s & FIB_TAPS); s' = {s[WIDTH-2:0], fb}; output bit = fb.
//  - Galois step: m = s[WIDTH-1]; s' = (s << 1) ^ ({WIDTH{m}} & GAL_POLY); output bit = m.
//  - Advance (en_i=1, n = min(steps_i, STEPS_MAX) > 0): apply n chained steps in one cycle.
//    state_o <= state after step n; bits_o[k-1] <= bit of step k for k <= n; others 0.
//  - Latency: state_o, bits_o and wrap_o update on the edge that samples en_i.
//  - Hold (en_i=0 or n=0): state_o, step_cnt, period_o unchanged; bits_o <= 0; wrap_o <= 0.
//  - step_cnt (WIDTH bits) adds n per advance; saturates at all-ones.
//  - Wrap: if any intermediate state k (1..n) == seed_q, wrap_o <= 1.
//    On the first such wrap with period_valid_o=0, take the smallest matching k:
//    period_o <= step_cnt + k, period_valid_o <= 1.
//    Later wraps pulse wrap_o but do not change period_o.
//  - A state of 0 is unreachable in either mode (nonzero seed forced). Mode switching mid-run is legal.
//    Period then measures the mixed sequence.
//  - Load asserted mid-advance: load wins; no step applied that cycle.
// STRUCTURE
//  - lfsr_pkg:
//    typedef enum logic {LFSR_FIB=1'b0, LFSR_GALOIS=1'b1} lfsr_mode_e;
//    default tap constants LFSR16_FIB_TAPS=16'hB400 and LFSR16_GAL_POLY=16'h002D.
//  - Sub-module lfsr_step: combinational single step (state, mode -> next state, out bit).
//    It is parametrised by WIDTH/FIB_TAPS/GAL_POLY and instantiated STEPS_MAX times in a generate chain.
//  - Top holds state, seed_q, step_cnt, period, pulse registers, and the per-stage seed comparators.
// TESTING
//  1. Reset with seed 16'hACE1, Fibonacci, steps 1, en 1 for 1 cycle -> state 16'h59C3, bits_o 8'h01.
//  2. Reset seed 16'hACE1, Fibonacci, steps 2 -> state 16'hB387, bits_o 8'h03.
//     Then steps 0 with en 1 -> state holds, bits_o 0.
//  3. Reset seed 16'hACE1, Galois, steps 1 -> state 16'h59EF, bits_o 8'h01.
//     Then steps 12 -> clamped to 8 steps (compare against model).
//  4. load_i with seed_i 0 -> state 16'h0001, lockup_o pulses exactly 1 cycle.
//     Same cycle en_i=1 -> no advance.
//  5. Seed 16'h0001, Fibonacci, steps 8, en continuous -> wrap_o at cycle 8192.
//     period_o 65535, period_valid_o 1. Repeat Galois -> 65535.
//  6. Assert nReset mid-run with seed 16'h1234 -> next cycle state 16'h1234.
//     All pulses 0, period_valid_o 0. Reference model compared every cycle under random en/steps/mode.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and default polynomial constants for the multi-step LFSR engine.
package lfsr_pkg;

    typedef enum logic {LFSR_FIB = 1'b0, LFSR_GALOIS = 1'b1} lfsr_mode_e;

    // x^16+x^14+x^13+x^11+1 as a Fibonacci tap mask, x^16+x^5+x^3+x^2+1 as a Galois feedback mask
    localparam logic [15:0] LFSR16_FIB_TAPS = 16'hB400;
    localparam logic [15:0] LFSR16_GAL_POLY = 16'h002D;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step in either Fibonacci or Galois form; chained by the engine.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(LFSR16_FIB_TAPS),
    parameter logic [WIDTH-1:0] GAL_POLY = WIDTH'(LFSR16_GAL_POLY)
) (
    input  logic [WIDTH-1:0] state_i,
    input  lfsr_mode_e       mode_i,
    output logic [WIDTH-1:0] state_o,
    output logic             bit_o
);

    logic fb;
    logic msb;

    assign fb  = ^(state_i & FIB_TAPS);
    assign msb = state_i[WIDTH-1];

    always_comb begin
        if (mode_i == LFSR_FIB) begin
            state_o = {state_i[WIDTH-2:0], fb};
            bit_o   = fb;
        end else begin
            state_o = (state_i << 1) ^ ({WIDTH{msb}} & GAL_POLY);
            bit_o   = msb;
        end
    end

endmodule

// File: rtl/lfsr_engine.sv
// Multi-step LFSR with seed load, zero-seed lockup recovery and period measurement
// against the most recently loaded seed.
module lfsr_engine
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] FIB_TAPS  = WIDTH'(LFSR16_FIB_TAPS),
    parameter logic [WIDTH-1:0] GAL_POLY  = WIDTH'(LFSR16_GAL_POLY),
    parameter int               STEPS_MAX = 8,
    parameter int               SW        = $clog2(STEPS_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic [WIDTH-1:0]     seed_i,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic                 mode_i,
    input  logic [SW-1:0]        steps_i,
    output logic [WIDTH-1:0]     state_o,
    output logic [STEPS_MAX-1:0] bits_o,
    output logic                 wrap_o,
    output logic                 lockup_o,
    output logic [WIDTH-1:0]     period_o,
    output logic                 period_valid_o
);

    localparam logic [SW-1:0] NMAX = SW'(STEPS_MAX);

    logic [WIDTH-1:0]     seed_q;
    logic [WIDTH-1:0]     step_cnt;
    logic [WIDTH-1:0]     chain [0:STEPS_MAX];
    logic [STEPS_MAX-1:0] step_bit;
    logic [SW-1:0]        n_steps;
    logic [WIDTH-1:0]     seed_fixed;
    logic                 seed_zero;
    logic [WIDTH-1:0]     adv_state;
    logic [STEPS_MAX-1:0] adv_bits;
    logic                 hit_any;
    logic [WIDTH-1:0]     first_k;
    logic [WIDTH:0]       cnt_sum;
    logic [WIDTH:0]       per_sum;

    assign n_steps    = (steps_i > NMAX) ? NMAX : steps_i;
    assign seed_zero  = (seed_i == '0);
    assign seed_fixed = seed_zero ? WIDTH'(1) : seed_i;
    assign chain[0]   = state_o;

    for (genvar g = 0; g < STEPS_MAX; g++) begin : g_step
        lfsr_step #(
            .WIDTH    (WIDTH),
            .FIB_TAPS (FIB_TAPS),
            .GAL_POLY (GAL_POLY)
        ) u_step (
            .state_i (chain[g]),
            .mode_i  (lfsr_mode_e'(mode_i)),
            .state_o (chain[g+1]),
            .bit_o   (step_bit[g])
        );
    end

    // Descending scan so the smallest matching stage is the one left in first_k
    always_comb begin
        adv_state = state_o;
        adv_bits  = '0;
        hit_any   = 1'b0;
        first_k   = '0;
        for (int k = STEPS_MAX - 1; k >= 0; k--) begin
            if (k < int'(n_steps)) begin
                adv_bits[k] = step_bit[k];
                if (chain[k+1] == seed_q) begin
                    hit_any = 1'b1;
                    first_k = WIDTH'(k + 1);
                end
            end
            if (k + 1 == int'(n_steps)) begin
                adv_state = chain[k+1];
            end
        end
    end

    assign cnt_sum = {1'b0, step_cnt} + {{(WIDTH + 1 - SW){1'b0}}, n_steps};
    assign per_sum = {1'b0, step_cnt} + {1'b0, first_k};

    always_ff @(posedge clk) begin
        if (nReset || load_i) begin
            state_o        <= seed_fixed;
            seed_q         <= seed_fixed;
            step_cnt       <= '0;
            bits_o         <= '0;
            wrap_o         <= 1'b0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            lockup_o       <= !nReset && seed_zero;
        end else if (en_i && (n_steps != '0)) begin
            state_o  <= adv_state;
            step_cnt <= cnt_sum[WIDTH] ? '1 : cnt_sum[WIDTH-1:0];
            bits_o   <= adv_bits;
            wrap_o   <= hit_any;
            lockup_o <= 1'b0;
            if (hit_any && !period_valid_o) begin
                period_o       <= per_sum[WIDTH] ? '1 : per_sum[WIDTH-1:0];
                period_valid_o <= 1'b1;
            end
        end else begin
            bits_o   <= '0;
            wrap_o   <= 1'b0;
            lockup_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench for lfsr_engine: directed vectors plus a per-cycle behavioural model.
module tb_lfsr_engine;

    logic        clk;
    logic        nReset;
    logic [15:0] seed_i;
    logic        load_i;
    logic        en_i;
    logic        mode_i;
    logic [3:0]  steps_i;
    logic [15:0] state_o;
    logic [7:0]  bits_o;
    logic        wrap_o;
    logic        lockup_o;
    logic [15:0] period_o;
    logic        period_valid_o;

    int checks = 0;
    int fails  = 0;

    logic [15:0] m_state, m_seed, m_period;
    logic [7:0]  m_bits;
    logic        m_wrap, m_lockup, m_pv;
    int          m_cnt;
    logic        model_live = 1'b0;

    lfsr_engine dut (
        .clk            (clk),
        .nReset         (nReset),
        .seed_i         (seed_i),
        .load_i         (load_i),
        .en_i           (en_i),
        .mode_i         (mode_i),
        .steps_i        (steps_i),
        .state_o        (state_o),
        .bits_o         (bits_o),
        .wrap_o         (wrap_o),
        .lockup_o       (lockup_o),
        .period_o       (period_o),
        .period_valid_o (period_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit 16 is the step's output bit, bits 15:0 the next state
    function automatic logic [16:0] modelStep(input logic [15:0] s, input logic galois);
        logic fb;
        if (!galois) begin
            fb = ($countones(s & 16'hB400) % 2) == 1;
            return {fb, s[14:0], fb};
        end
        if (s[15]) return {1'b1, (s << 1) ^ 16'h002D};
        return {1'b0, s << 1};
    endfunction

    // Model updates on the sampling edge, then compares once the DUT has settled
    always @(posedge clk) begin
        int n, hit;
        logic [16:0] r;
        logic [15:0] s, v;
        if (nReset || load_i) begin
            v        = (seed_i == 16'h0) ? 16'h0001 : seed_i;
            m_state  = v;
            m_seed   = v;
            m_cnt    = 0;
            m_bits   = 8'h00;
            m_wrap   = 1'b0;
            m_pv     = 1'b0;
            m_period = 16'h0;
            m_lockup = !nReset && (seed_i == 16'h0);
            if (nReset) model_live = 1'b1;
        end else if (en_i && steps_i != 0) begin
            n      = (steps_i > 8) ? 8 : int'(steps_i);
            s      = m_state;
            hit    = 0;
            m_bits = 8'h00;
            for (int k = 1; k <= n; k++) begin
                r = modelStep(s, mode_i);
                s = r[15:0];
                m_bits[k-1] = r[16];
                if (s == m_seed && hit == 0) hit = k;
            end
            m_state = s;
            m_wrap  = (hit != 0);
            if (hit != 0 && !m_pv) begin
                m_period = 16'((m_cnt + hit > 65535) ? 65535 : m_cnt + hit);
                m_pv     = 1'b1;
            end
            m_cnt    = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
            m_lockup = 1'b0;
        end else begin
            m_bits   = 8'h00;
            m_wrap   = 1'b0;
            m_lockup = 1'b0;
        end
        #1;
        if (model_live) begin
            checkOutput("model state_o", 32'(state_o), 32'(m_state));
            checkOutput("model bits_o", 32'(bits_o), 32'(m_bits));
            checkOutput("model wrap_o", 32'(wrap_o), 32'(m_wrap));
            checkOutput("model lockup_o", 32'(lockup_o), 32'(m_lockup));
            checkOutput("model period_o", 32'(period_o), 32'(m_period));
            checkOutput("model period_valid_o", 32'(period_valid_o), 32'(m_pv));
        end
    end

    task automatic applyStimulus(input logic rst, input logic ld, input logic en,
                                 input logic md, input logic [3:0] st, input logic [15:0] sd);
        @(negedge clk);
        nReset  = rst;
        load_i  = ld;
        en_i    = en;
        mode_i  = md;
        steps_i = st;
        seed_i  = sd;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int cyc;
        nReset  = 1'b0;
        load_i  = 1'b0;
        en_i    = 1'b0;
        mode_i  = 1'b0;
        steps_i = 4'd0;
        seed_i  = 16'h0;

        // Reset state and single/double Fibonacci steps from ACE1
        applyStimulus(1, 0, 0, 0, 0, 16'hACE1);
        checkOutput("reset state", 32'(state_o), 32'hACE1);
        checkOutput("reset period_valid", 32'(period_valid_o), 32'h0);
        checkOutput("reset bits", 32'(bits_o), 32'h0);
        applyStimulus(0, 0, 1, 0, 1, 16'h0);
        checkOutput("fib 1 step state", 32'(state_o), 32'h59C3);
        checkOutput("fib 1 step bits", 32'(bits_o), 32'h01);

        applyStimulus(1, 0, 0, 0, 0, 16'hACE1);
        applyStimulus(0, 0, 1, 0, 2, 16'h0);
        checkOutput("fib 2 step state", 32'(state_o), 32'hB387);
        checkOutput("fib 2 step bits", 32'(bits_o), 32'h03);
        applyStimulus(0, 0, 1, 0, 0, 16'h0);
        checkOutput("steps 0 hold state", 32'(state_o), 32'hB387);
        checkOutput("steps 0 hold bits", 32'(bits_o), 32'h0);

        // Galois step and clamping of an oversize step request
        applyStimulus(1, 0, 0, 1, 0, 16'hACE1);
        applyStimulus(0, 0, 1, 1, 1, 16'h0);
        checkOutput("galois 1 step state", 32'(state_o), 32'h59EF);
        checkOutput("galois 1 step bits", 32'(bits_o), 32'h01);
        applyStimulus(0, 0, 1, 1, 12, 16'h0);
        applyStimulus(0, 0, 1, 1, 15, 16'h0);

        // Zero-seed load with simultaneous enable, and zero seed on reset
        applyStimulus(0, 1, 1, 0, 3, 16'h0000);
        checkOutput("zero load state", 32'(state_o), 32'h0001);
        checkOutput("zero load lockup", 32'(lockup_o), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0);
        checkOutput("lockup pulse width", 32'(lockup_o), 32'h0);
        checkOutput("idle after load state", 32'(state_o), 32'h0001);
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        checkOutput("zero reset state", 32'(state_o), 32'h0001);
        checkOutput("zero reset lockup", 32'(lockup_o), 32'h0);

        // Full Fibonacci period from seed 1 at 8 steps per clock
        applyStimulus(1, 0, 0, 0, 0, 16'h0001);
        cyc = 0;
        while (cyc < 9000) begin
            applyStimulus(0, 0, 1, 0, 8, 16'h0);
            cyc++;
            if (wrap_o) break;
        end
        checkOutput("fib wrap cycle", 32'(cyc), 32'd8192);
        checkOutput("fib period", 32'(period_o), 32'd65535);
        checkOutput("fib period_valid", 32'(period_valid_o), 32'h1);
        applyStimulus(0, 0, 1, 0, 8, 16'h0);
        checkOutput("fib wrap pulse width", 32'(wrap_o), 32'h0);

        // Full Galois period from seed 1
        applyStimulus(1, 0, 0, 1, 0, 16'h0001);
        cyc = 0;
        while (cyc < 9000) begin
            applyStimulus(0, 0, 1, 1, 8, 16'h0);
            cyc++;
            if (wrap_o) break;
        end
        checkOutput("galois wrap seen", 32'(wrap_o), 32'h1);
        checkOutput("galois period_valid", 32'(period_valid_o), 32'h1);

        // Random run, mid-run reset, then random run with occasional loads
        for (int i = 0; i < 40; i++)
            applyStimulus(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 16'h0);
        applyStimulus(1, 0, 1, 0, 5, 16'h1234);
        checkOutput("mid reset state", 32'(state_o), 32'h1234);
        checkOutput("mid reset wrap", 32'(wrap_o), 32'h0);
        checkOutput("mid reset lockup", 32'(lockup_o), 32'h0);
        checkOutput("mid reset period_valid", 32'(period_valid_o), 32'h0);
        for (int i = 0; i < 400; i++)
            applyStimulus(0, ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
